// File: rtl/i2c_pkg.sv
// Shared widths, FSM state codes and transfer-direction constants for the I2C master.
package i2c_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ADDR_W = 7;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ADDRESSING = 3'd1,
    WAITING    = 3'd2,
    READING    = 3'd3,
    WRITING    = 3'd4,
    DONE       = 3'd5
  } state_t;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  localparam logic [CNT_W-1:0] BITS_PER_BYTE = CNT_W'(BYTE_W);

endpackage

// File: rtl/i2c_shift_reg.sv
// 8-bit shift register with bit counter; serves the address, write and read datapaths.
module i2c_shift_reg
  import i2c_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [BYTE_W-1:0] load_data,
  input  logic              shift_out,
  input  logic              shift_in,
  input  logic              in_bit,
  output logic [BYTE_W-1:0] data,
  output logic [CNT_W-1:0]  count
);

  // Load clears the counter; each shift (either direction) counts one bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      count <= '0;
    end else if (load) begin
      data  <= load_data;
      count <= '0;
    end else if (shift_out) begin
      data  <= {data[BYTE_W-2:0], 1'b0};
      count <= count + CNT_W'(1);
    end else if (shift_in) begin
      data  <= {data[BYTE_W-2:0], in_bit};
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-transaction I2C master: START, address+R/W, ACK check, one byte read or
// write, STOP, then parks in DONE until reset.
module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SLAVE_ADDR = 7'h50
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rw,
  input  logic [BYTE_W-1:0] data_in,
  output logic [BYTE_W-1:0] data_out,
  output logic [2:0]        state,
  output logic              sclk,
  input  logic              sda_in,
  output logic              sda_out
);

  state_t              state_q;
  state_t              state_nxt;
  logic                sclk_nxt;
  logic                sda_nxt;
  logic                rw_lat;
  logic [BYTE_W-1:0]   data_lat;
  logic                ack_q;
  logic                ack_nxt;
  logic                wrote_q;
  logic                wrote_nxt;
  logic                sh_load;
  logic [BYTE_W-1:0]   sh_load_data;
  logic                sh_shift_out;
  logic                sh_shift_in;
  logic [BYTE_W-1:0]   sh_data;
  logic [CNT_W-1:0]    sh_count;
  logic                dout_load;

  assign state = state_q;

  i2c_shift_reg u_shift (
    .clk       (clk),
    .rst       (rst),
    .load      (sh_load),
    .load_data (sh_load_data),
    .shift_out (sh_shift_out),
    .shift_in  (sh_shift_in),
    .in_bit    (sda_in),
    .data      (sh_data),
    .count     (sh_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sclk    <= 1'b1;
      sda_out <= 1'b1;
      ack_q   <= 1'b0;
      wrote_q <= 1'b0;
    end else begin
      state_q <= state_nxt;
      sclk    <= sclk_nxt;
      sda_out <= sda_nxt;
      ack_q   <= ack_nxt;
      wrote_q <= wrote_nxt;
    end
  end

  // Transaction parameters are captured on the edge that leaves IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rw_lat   <= WRITE;
      data_lat <= '0;
    end else if (state_q == IDLE) begin
      rw_lat   <= rw;
      data_lat <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= '0;
    end else if (dout_load) begin
      data_out <= {sh_data[BYTE_W-2:0], sda_in};
    end
  end

  // In active states sclk==1 means this edge is a falling SCL edge (drive SDA),
  // sclk==0 means a rising SCL edge (sample SDA).
  always_comb begin
    state_nxt    = state_q;
    sclk_nxt     = sclk;
    sda_nxt      = sda_out;
    ack_nxt      = ack_q;
    wrote_nxt    = wrote_q;
    sh_load      = 1'b0;
    sh_load_data = '0;
    sh_shift_out = 1'b0;
    sh_shift_in  = 1'b0;
    dout_load    = 1'b0;

    case (state_q)
      IDLE: begin
        sda_nxt      = 1'b0;
        sh_load      = 1'b1;
        sh_load_data = {SLAVE_ADDR, rw};
        wrote_nxt    = 1'b0;
        state_nxt    = ADDRESSING;
      end

      ADDRESSING, WRITING: begin
        sclk_nxt = ~sclk;
        if (sclk) begin
          if (sh_count == BITS_PER_BYTE) begin
            sda_nxt   = 1'b1;
            wrote_nxt = (state_q == WRITING);
            state_nxt = WAITING;
          end else begin
            sda_nxt      = sh_data[BYTE_W-1];
            sh_shift_out = 1'b1;
          end
        end
      end

      WAITING: begin
        sclk_nxt = ~sclk;
        if (!sclk) begin
          // Preload the write byte here so its MSB is ready for the falling edge.
          ack_nxt      = ~sda_in;
          sh_load      = 1'b1;
          sh_load_data = data_lat;
        end else if (!ack_q || wrote_q) begin
          sda_nxt   = 1'b0;
          state_nxt = DONE;
        end else if (rw_lat == READ) begin
          state_nxt = READING;
        end else begin
          sda_nxt      = sh_data[BYTE_W-1];
          sh_shift_out = 1'b1;
          state_nxt    = WRITING;
        end
      end

      READING: begin
        sclk_nxt = ~sclk;
        if (!sclk) begin
          // Ninth rising edge is the master NACK pulse; counting it marks the exit.
          sh_shift_in = (sh_count <= BITS_PER_BYTE);
          dout_load   = (sh_count == BITS_PER_BYTE - CNT_W'(1));
        end else if (sh_count > BITS_PER_BYTE) begin
          sda_nxt   = 1'b0;
          state_nxt = DONE;
        end
      end

      DONE: begin
        if (!sclk) begin
          sclk_nxt = 1'b1;
        end else begin
          sda_nxt = 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Scoreboard bench: a protocol-level slave and bus monitor check START/bits/STOP,
// state sequence, timing and data_out against expectations queued per transaction.
module tb_i2c_master_ctrl;

  localparam logic [6:0] ADDR     = 7'h50;
  localparam int         EV_START = 2;
  localparam int         EV_STOP  = 3;
  localparam int         N_RANDOM = 10;

  logic       clk     = 1'b0;
  logic       rst     = 1'b1;
  logic       rw      = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       sda_in  = 1'b1;
  logic [7:0] data_out;
  logic [2:0] state;
  logic       sclk;
  logic       sda_out;

  int checks = 0;
  int errors = 0;

  int         exp_bus[$];
  int         exp_state[$];
  logic [7:0] exp_dout = 8'h00;
  int         n_bits = 0;

  logic       s_ack_addr = 1'b1;
  logic       s_ack_data = 1'b1;
  logic [7:0] s_rd_byte  = 8'h00;
  int         s_cnt      = 0;
  logic [7:0] s_shift    = 8'h00;
  logic       s_acked    = 1'b0;

  logic       p_sclk  = 1'b1;
  logic       p_sda   = 1'b1;
  logic [2:0] p_state = 3'd0;
  int cyc = 0;
  int start_cyc = 0;
  int stop_cyc = 0;
  int stops_seen = 0;
  int stops_before = 0;

  always #5 clk = ~clk;

  i2c_master_ctrl #(.SLAVE_ADDR(ADDR)) dut (
    .clk      (clk),
    .rst      (rst),
    .rw       (rw),
    .data_in  (data_in),
    .data_out (data_out),
    .state    (state),
    .sclk     (sclk),
    .sda_in   (sda_in),
    .sda_out  (sda_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Bus monitor and slave responder, both acting between clk edges.
  always @(negedge clk) begin : monitor
    int obs;
    int nxt;
    cyc++;
    if (rst) begin
      p_sclk  = 1'b1;
      p_sda   = 1'b1;
      p_state = 3'd0;
      s_cnt   = 0;
      sda_in  = 1'b1;
    end else begin
      obs = -1;
      if (state != p_state) begin
        if (exp_state.size() == 0) check("state_extra", 32'(state), 32'hFFFF_FFFF);
        else check("state_seq", 32'(state), 32'(exp_state.pop_front()));
      end
      if (p_sclk && sclk && p_sda && !sda_out) begin
        obs = EV_START;
        start_cyc = cyc;
        s_cnt = 0;
        s_acked = 1'b0;
        sda_in = 1'b1;
      end else if (p_sclk && sclk && !p_sda && sda_out) begin
        obs = EV_STOP;
        stop_cyc = cyc;
        stops_seen++;
      end else if (!p_sclk && sclk) begin
        obs = int'(sda_out);
        s_cnt++;
        if (s_cnt <= 8) s_shift = {s_shift[6:0], sda_out};
      end else if (p_sclk && !sclk) begin
        nxt = s_cnt + 1;
        if (nxt == 9) begin
          s_acked = s_ack_addr && (s_shift[7:1] == ADDR);
          sda_in  = !s_acked;
        end else if (s_acked && s_shift[0] && nxt >= 10 && nxt <= 17) begin
          sda_in = s_rd_byte[3'(17 - nxt)];
        end else if (s_acked && !s_shift[0] && nxt == 18) begin
          sda_in = !s_ack_data;
        end else begin
          sda_in = 1'b1;
        end
      end
      if (obs >= 0) begin
        if (exp_bus.size() == 0) check("bus_extra", 32'(obs), 32'hFFFF_FFFF);
        else check("bus_event", 32'(obs), 32'(exp_bus.pop_front()));
      end
      p_sclk  = sclk;
      p_sda   = sda_out;
      p_state = state;
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_sclk"}, 32'(sclk), 32'd1);
    check({tag, "_sda"}, 32'(sda_out), 32'd1);
    check({tag, "_dout"}, 32'(data_out), 32'd0);
  endtask

  task automatic start_txn(input logic r, input logic [7:0] d, input logic aa,
                           input logic ad, input logic [7:0] rb);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_values("rst");
    rw = r;
    data_in = d;
    s_ack_addr = aa;
    s_ack_data = ad;
    s_rd_byte = rb;
    exp_bus.delete();
    exp_state.delete();
    exp_dout = 8'h00;
    exp_bus.push_back(EV_START);
    for (int i = 6; i >= 0; i--) exp_bus.push_back(int'(ADDR[i]));
    exp_bus.push_back(int'(r));
    exp_bus.push_back(1);
    exp_state.push_back(1);
    exp_state.push_back(2);
    if (aa) begin
      if (r) begin
        exp_state.push_back(3);
        repeat (9) exp_bus.push_back(1);
        exp_dout = rb;
      end else begin
        exp_state.push_back(4);
        exp_state.push_back(2);
        for (int i = 7; i >= 0; i--) exp_bus.push_back(int'(d[i]));
        exp_bus.push_back(1);
      end
    end
    exp_state.push_back(5);
    exp_bus.push_back(0);
    exp_bus.push_back(EV_STOP);
    n_bits = exp_bus.size() - 2;
    stops_before = stops_seen;
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1 rw = ~r;
    data_in = ~d;
  endtask

  task automatic finish_txn();
    int n = 0;
    while (stops_seen == stops_before && n < 300) begin
      @(posedge clk);
      n++;
    end
    check("stop_seen", 32'(stops_seen - stops_before), 32'd1);
    repeat (4) @(negedge clk);
    check("end_state", 32'(state), 32'd5);
    check("end_sclk", 32'(sclk), 32'd1);
    check("end_sda", 32'(sda_out), 32'd1);
    check("data_out", 32'(data_out), 32'(exp_dout));
    check("bus_left", 32'(exp_bus.size()), 32'd0);
    check("state_left", 32'(exp_state.size()), 32'd0);
    check("txn_cycles", 32'(stop_cyc - start_cyc), 32'(2 * n_bits + 1));
  endtask

  task automatic abort_during_read(input logic [7:0] rb);
    int n = 0;
    while (!(state == 3'd3 && data_out == rb) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("abort_pre_dout", 32'(data_out), 32'(rb));
    check("abort_pre_state", 32'(state), 32'd3);
    #2 rst = 1'b1;
    #1 check_reset_values("abort_rst");
    exp_bus.delete();
    exp_state.delete();
    repeat (3) @(posedge clk);
    check("abort_no_stop", 32'(stops_seen - stops_before), 32'd0);
    #1 check("abort_hold_state", 32'(state), 32'd0);
  endtask

  initial begin : stimulus
    logic       r;
    logic       aa;
    logic       ad;
    logic [7:0] d;
    logic [7:0] rb;

    start_txn(1'b1, 8'h00, 1'b1, 1'b1, 8'hF6);
    finish_txn();

    start_txn(1'b0, 8'hA5, 1'b1, 1'b1, 8'h00);
    finish_txn();

    start_txn(1'b1, 8'h3C, 1'b0, 1'b1, 8'h55);
    finish_txn();

    start_txn(1'b1, 8'h00, 1'b1, 1'b1, 8'h3C);
    abort_during_read(8'h3C);

    for (int t = 0; t < N_RANDOM; t++) begin
      r  = 1'($urandom);
      d  = 8'($urandom);
      aa = ($urandom_range(0, 3) != 0);
      ad = 1'($urandom);
      rb = 8'($urandom);
      start_txn(r, d, aa, ad, rb);
      finish_txn();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
